// File: rtl/sisc_fetch_pkg.sv
// Shared types and helpers for the SISC fetch unit: FSM state encoding, default widths and
// the branch-redirect target calculation.
package sisc_fetch_pkg;

  localparam int unsigned SISC_INSTR_W  = 32;
  localparam int unsigned SISC_ADDR_W   = 16;
  // Widest supported address; callers truncate the result to their own ADDR_W.
  localparam int unsigned SISC_TARGET_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  // Relative offsets are two's complement in the caller's width, so zero-extending both
  // operands and truncating the sum afterwards still gives the correct modulo-2^ADDR_W result.
  function automatic logic [SISC_TARGET_W-1:0] redirect_target(
    input logic                     abs_sel,
    input logic [SISC_TARGET_W-1:0] base,
    input logic [SISC_TARGET_W-1:0] off
  );
    return abs_sel ? off : base + off;
  endfunction

endpackage

// File: rtl/sisc_sync_fifo.sv
// Synchronous prefetch FIFO with flush. DEPTH must be a power of two so the pointers wrap
// naturally; count is one bit wider than the pointers to distinguish full from empty.
module sisc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_f,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_push = push && (count_q != CntW'(DEPTH));
  assign do_pop  = pop && (count_q != '0);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (rst_f && !flush && do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// Decoupled SISC instruction fetch: owns the PC, keeps one request in flight, buffers words
// in a prefetch FIFO. Define FETCH_BYPASS_EN for zero-latency forwarding into an empty FIFO.
module sisc_fetch_unit
  import sisc_fetch_pkg::*;
#(
  parameter int unsigned INSTR_W  = SISC_INSTR_W,
  parameter int unsigned ADDR_W   = SISC_ADDR_W,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst_f,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect,
  input  logic               redirect_abs,
  input  logic [ADDR_W-1:0]  redirect_base,
  input  logic [ADDR_W-1:0]  redirect_off,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_data,
  output logic [ADDR_W-1:0]  ir_pc
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CntW   = PtrW + 1;
  localparam int unsigned EntryW = INSTR_W + ADDR_W;

  fetch_state_t       state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  pend_pc_q, pend_pc_d;
  logic [ADDR_W-1:0]  target;
  logic [CntW-1:0]    count;
  logic [EntryW-1:0]  fifo_dout;
  logic               fifo_push, fifo_pop, fifo_valid, accept_rsp;
  logic [INSTR_W-1:0] head_data;
  logic [ADDR_W-1:0]  head_pc;

  assign target = ADDR_W'(redirect_target(redirect_abs, SISC_TARGET_W'(redirect_base),
                                          SISC_TARGET_W'(redirect_off)));

  assign fifo_valid = (count != '0);
  assign head_data  = fifo_dout[EntryW-1 -: INSTR_W];
  assign head_pc    = fifo_dout[ADDR_W-1:0];
  // A response is only kept if it answers the live request and no redirect kills it.
  assign accept_rsp = (state_q == WAIT) && imem_valid && !redirect;

  assign imem_req  = rst_f && (state_q == IDLE) && (count < CntW'(DEPTH)) && !redirect;
  assign imem_addr = pc_q;

`ifdef FETCH_BYPASS_EN
  logic bypass;

  assign bypass    = accept_rsp && !fifo_valid;
  assign ir_valid  = fifo_valid || bypass;
  assign ir_data   = fifo_valid ? head_data : (bypass ? imem_rdata : '0);
  assign ir_pc     = fifo_valid ? head_pc : (bypass ? pend_pc_q : '0);
  assign fifo_push = accept_rsp && !(bypass && ir_ready);
  assign fifo_pop  = fifo_valid && ir_ready && !redirect;
`else
  assign ir_valid  = fifo_valid;
  assign ir_data   = fifo_valid ? head_data : '0;
  assign ir_pc     = fifo_valid ? head_pc : '0;
  assign fifo_push = accept_rsp;
  assign fifo_pop  = fifo_valid && ir_ready && !redirect;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    unique case (state_q)
      IDLE: begin
        if (imem_req) begin
          state_d   = WAIT;
          pc_d      = pc_q + ADDR_W'(1);
          pend_pc_d = pc_q;
        end
      end
      WAIT: begin
        if (redirect)        state_d = imem_valid ? IDLE : DROP;
        else if (imem_valid) state_d = IDLE;
      end
      DROP: begin
        if (imem_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (redirect) pc_d = target;
  end

  always_ff @(posedge clk) begin
    if (!rst_f) begin
      state_q   <= IDLE;
      pc_q      <= ADDR_W'(RESET_PC);
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  sisc_sync_fifo #(
    .WIDTH (EntryW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_f (rst_f),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (redirect),
    .din   ({imem_rdata, pend_pc_q}),
    .dout  (fifo_dout),
    .count (count)
  );

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit with a variable-latency instruction memory model.
module tb_sisc_fetch_unit;

`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic        redirect_abs = 1'b0;
  logic [15:0] redirect_base = '0;
  logic [15:0] redirect_off = '0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_data;
  logic [15:0] ir_pc;

  int          n_checks = 0;
  int          n_err = 0;
  int          lat = 1;
  int          n_req = 0;
  int          mem_wait = 0;
  logic        mem_busy = 1'b0;
  logic [15:0] mem_addr = '0;
  logic [15:0] last_addr = '0;

  sisc_fetch_unit u_dut (
    .clk           (clk),
    .rst_f         (rst_f),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .redirect      (redirect),
    .redirect_abs  (redirect_abs),
    .redirect_base (redirect_base),
    .redirect_off  (redirect_off),
    .ir_valid      (ir_valid),
    .ir_ready      (ir_ready),
    .ir_data       (ir_data),
    .ir_pc         (ir_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] instr_of(input logic [15:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock; the memory model sees the request of the cycle just ending and answers
  // exactly lat cycles after it.
  task automatic cycle();
    logic        req_now;
    logic        had_valid;
    logic [15:0] a_now;
    #1;
    req_now   = imem_req;
    a_now     = imem_addr;
    had_valid = imem_valid;
    @(posedge clk);
    #1;
    if (!rst_f) begin
      mem_busy   = 1'b0;
      imem_valid = 1'b0;
    end else begin
      if (had_valid) begin
        imem_valid = 1'b0;
        mem_busy   = 1'b0;
      end
      if (req_now) begin
        n_req++;
        last_addr = a_now;
        mem_busy  = 1'b1;
        mem_addr  = a_now;
        mem_wait  = lat - 1;
      end else if (mem_busy && mem_wait > 0) begin
        mem_wait--;
      end
      if (mem_busy && mem_wait == 0) begin
        imem_valid = 1'b1;
        imem_rdata = instr_of(mem_addr);
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_f    = 1'b0;
    redirect = 1'b0;
    cycle();
    cycle();
    rst_f = 1'b1;
    #1;
  endtask

  // Waits (bounded) for the next head instruction, checks it, then consumes it.
  task automatic wait_ir(input logic [15:0] exp_pc, input string tag);
    for (int i = 0; i < 16 && !ir_valid; i++) cycle();
    chk({tag, "_valid"}, 32'(ir_valid), 32'd1);
    chk({tag, "_pc"}, 32'(ir_pc), 32'(exp_pc));
    chk({tag, "_data"}, ir_data, instr_of(exp_pc));
    cycle();
  endtask

  initial begin
    // Reset and sequential fetch
    rst_f    = 1'b0;
    ir_ready = 1'b1;
    cycle();
    cycle();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_ir_valid", 32'(ir_valid), 32'd0);
    chk("rst_ir_data", ir_data, 32'd0);
    chk("rst_ir_pc", 32'(ir_pc), 32'd0);
    rst_f = 1'b1;
    #1;
    chk("boot_req", 32'(imem_req), 32'd1);
    chk("boot_addr", 32'(imem_addr), 32'd0);
    chk("boot_ir_valid", 32'(ir_valid), 32'd0);
    for (int k = 0; k < 4; k++) wait_ir(16'(k), "seq");

    // Full stall with DEPTH=4
    do_reset();
    ir_ready = 1'b0;
    lat      = 1;
    n_req    = 0;
    repeat (12) cycle();
    chk("stall_nreq", 32'(n_req), 32'd4);
    chk("stall_last", 32'(last_addr), 32'd3);
    chk("stall_req", 32'(imem_req), 32'd0);
    chk("stall_head_pc", 32'(ir_pc), 32'd0);
    chk("stall_head_data", ir_data, instr_of(16'd0));
    ir_ready = 1'b1;
    cycle();
    ir_ready = 1'b0;
    chk("pop_req", 32'(imem_req), 32'd1);
    chk("pop_addr", 32'(imem_addr), 32'd4);
    chk("pop_head_pc", 32'(ir_pc), 32'd1);
    cycle();
    chk("pop_nreq", 32'(n_req), 32'd5);

    // Absolute redirect over an outstanding 3-cycle request to address 5
    do_reset();
    ir_ready = 1'b1;
    lat      = 1;
    for (int i = 0; i < 40 && !(imem_req && imem_addr == 16'd5); i++) cycle();
    chk("red_found", 32'(imem_req && imem_addr == 16'd5), 32'd1);
    lat      = 3;
    ir_ready = 1'b0;
    cycle();
    redirect     = 1'b1;
    redirect_abs = 1'b1;
    redirect_off = 16'h0040;
    #1;
    chk("red_noreq", 32'(imem_req), 32'd0);
    cycle();
    redirect     = 1'b0;
    redirect_abs = 1'b0;
    redirect_off = '0;
    #1;
    chk("drop_addr", 32'(imem_addr), 32'h40);
    chk("drop_req", 32'(imem_req), 32'd0);
    chk("drop_ir_valid", 32'(ir_valid), 32'd0);
    cycle();
    chk("late_ir_valid", 32'(ir_valid), 32'd0);
    cycle();
    chk("refetch_req", 32'(imem_req), 32'd1);
    chk("refetch_addr", 32'(imem_addr), 32'h40);
    ir_ready = 1'b1;
    lat      = 1;
    wait_ir(16'h0040, "refetch");

    // Relative redirect wrapping past 0xFFFF, then sequential wrap
    redirect      = 1'b1;
    redirect_abs  = 1'b0;
    redirect_base = 16'hFFFE;
    redirect_off  = 16'h0003;
    cycle();
    redirect      = 1'b0;
    redirect_base = '0;
    redirect_off  = '0;
    #1;
    chk("rel_pc", 32'(imem_addr), 32'd1);
    for (int i = 0; i < 10 && !imem_req; i++) cycle();
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", 32'(imem_addr), 32'd1);
    wait_ir(16'h0001, "rel");
    redirect     = 1'b1;
    redirect_abs = 1'b1;
    redirect_off = 16'hFFFF;
    cycle();
    redirect     = 1'b0;
    redirect_abs = 1'b0;
    redirect_off = '0;
    wait_ir(16'hFFFF, "wrap_hi");
    wait_ir(16'h0000, "wrap_lo");

    // Response, redirect and pop all in one cycle
    do_reset();
    ir_ready = 1'b0;
    lat      = 1;
    cycle();
    cycle();
    chk("sim_head_valid", 32'(ir_valid), 32'd1);
    chk("sim_head_pc", 32'(ir_pc), 32'd0);
    chk("sim_req_addr", 32'(imem_addr), 32'd1);
    cycle();
    redirect     = 1'b1;
    redirect_abs = 1'b1;
    redirect_off = 16'h0123;
    ir_ready     = 1'b1;
    #1;
    chk("sim_noreq", 32'(imem_req), 32'd0);
    cycle();
    redirect     = 1'b0;
    redirect_abs = 1'b0;
    redirect_off = '0;
    #1;
    chk("sim_ir_valid", 32'(ir_valid), 32'd0);
    chk("sim_req", 32'(imem_req), 32'd1);
    chk("sim_addr", 32'(imem_addr), 32'h123);
    wait_ir(16'h0123, "sim_next");

    // Response-to-ir_valid latency with an empty FIFO
    do_reset();
    ir_ready = 1'b1;
    lat      = 1;
    cycle();
    chk("lat_rsp_ir_valid", 32'(ir_valid), 32'(BYP));
    chk("lat_rsp_ir_data", ir_data, BYP ? instr_of(16'd0) : 32'd0);
    cycle();
    chk("lat_next_ir_valid", 32'(ir_valid), 32'(!BYP));
    chk("lat_next_req", 32'(imem_req), 32'd1);
    chk("lat_next_addr", 32'(imem_addr), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
